// File: rtl/bram_table_writer_pkg.sv
// Shared definitions for the BRAM table writer/reader pair: FSM state codes and default geometry.
// Latency: n/a (package only).
// Backpressure: n/a.
package bram_table_writer_pkg;

    // Default geometry. It matches the quarter-wave sine table the reader expects.
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    // The checksum holds DEPTH unsigned samples without overflow.
    function automatic int csum_w(input int data_w, input int depth);
        return data_w + $clog2(depth);
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid shift register that tags BRAM reads. It produces the strobe when the read data returns.
// Latency: out_vld follows in_vld by LAT cycles. any_vld is high while any read is in flight.
// Backpressure: none. It shifts every cycle.
// Ports: clk, rst_n (async, active-low), in_vld (read issued), out_vld (data valid now), any_vld.
module rd_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    output logic out_vld,
    output logic any_vld
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = in_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign any_vld = |vld_q;

endmodule

// File: rtl/bram_table_writer.sv
// Loads a DEPTH-entry table into BRAM port A from a valid/ready stream, reads it back and compares checksums.
// Latency: with no stalls, done/error is set 2*DEPTH+READ_LAT+1 cycles after start.
// Backpressure: s_ready is high only in WRITE. Each idle stream cycle delays completion by one cycle.
// Ports: CLK100MHZ/CPU_RESETN; start; s_valid/s_data/s_ready; BRAM port A (ena/wea/addra/dina/douta);
//        busy/done/error status for the sequencer.
module bram_table_writer
    import bram_table_writer_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ena,
    output logic [0:0]        wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int                CSUM_W    = csum_w(DATA_W, DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CSUM_W-1:0]   write_sum_q, write_sum_d;
    logic [CSUM_W-1:0]   read_sum_q, read_sum_d;
    logic                rd_issue;
    logic                acc_stb;
    logic                rd_pending;

    rd_lat_pipe #(
        .LAT (READ_LAT)
    ) u_rd_lat_pipe (
        .clk     (CLK100MHZ),
        .rst_n   (CPU_RESETN),
        .in_vld  (rd_issue),
        .out_vld (acc_stb),
        .any_vld (rd_pending)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_sum_d = write_sum_q;
        read_sum_d  = read_sum_q;
        s_ready     = 1'b0;
        ena         = 1'b0;
        wea         = 1'b0;
        addra       = '0;
        dina        = '0;
        rd_issue    = 1'b0;

        // Read data is accumulated when it returns, whatever the current state.
        if (acc_stb) begin
            read_sum_d = read_sum_q + CSUM_W'(douta);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    addr_d      = '0;
                    write_sum_d = '0;
                    read_sum_d  = '0;
                end
            end
            ST_WRITE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    ena         = 1'b1;
                    wea         = 1'b1;
                    addra       = addr_q;
                    dina        = s_data;
                    write_sum_d = write_sum_q + CSUM_W'(s_data);
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = ST_VERIFY;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                ena      = 1'b1;
                addra    = addr_q;
                rd_issue = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = ST_CHECK;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_CHECK: begin
                // An empty pipe means the last sample went into read_sum_q on the previous edge.
                if (!rd_pending) begin
                    state_d = (read_sum_q == write_sum_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_sum_q <= '0;
            read_sum_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_sum_q <= write_sum_d;
            read_sum_q  <= read_sum_d;
        end
    end

    assign busy  = (state_q == ST_WRITE) || (state_q == ST_VERIFY) || (state_q == ST_CHECK);
    assign done  = (state_q == ST_DONE);
    assign error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_bram_table_writer.sv
// Directed bench for bram_table_writer. It runs a READ_LAT=1 and a READ_LAT=2 instance in lockstep,
// each attached to its own behavioural BRAM.
// Expected edge numbers count the start-sampling edge as edge 0.
module tb_bram_table_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [10:0] s_data = '0;

    logic        s_ready1, ena1, busy1, done1, error1;
    logic [0:0]  wea1;
    logic [7:0]  addra1;
    logic [10:0] dina1, douta1;

    logic        s_ready2, ena2, busy2, done2, error2;
    logic [0:0]  wea2;
    logic [7:0]  addra2;
    logic [10:0] dina2, douta2;

    logic [10:0] mem1 [256];
    logic [10:0] mem2 [256];
    logic [10:0] q2;
    logic        corrupt = 1'b0;
    logic        run_clr = 1'b0;
    int          wr_cnt = 0;
    int          wr_bad = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bram_table_writer #(.READ_LAT(1)) u_dut1 (
        .CLK100MHZ (clk), .CPU_RESETN (rst_n), .start (start),
        .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready1),
        .ena (ena1), .wea (wea1), .addra (addra1), .dina (dina1), .douta (douta1),
        .busy (busy1), .done (done1), .error (error1)
    );

    bram_table_writer #(.READ_LAT(2)) u_dut2 (
        .CLK100MHZ (clk), .CPU_RESETN (rst_n), .start (start),
        .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready2),
        .ena (ena2), .wea (wea2), .addra (addra2), .dina (dina2), .douta (douta2),
        .busy (busy2), .done (done2), .error (error2)
    );

    // BRAM for dut1: read-first, no output register. Reads of address 5 can be corrupted.
    always @(posedge clk) begin
        if (ena1) begin
            if (wea1[0]) mem1[addra1] <= dina1;
            douta1 <= (corrupt && addra1 == 8'd5) ? mem1[addra1] + 11'd1 : mem1[addra1];
        end
    end

    // BRAM for dut2: primitive output register, so two cycles of read latency.
    always @(posedge clk) begin
        if (ena2) begin
            if (wea2[0]) mem2[addra2] <= dina2;
            q2 <= mem2[addra2];
        end
        douta2 <= q2;
    end

    // Write-order monitor: every write must land at the next sequential address.
    always @(posedge clk) begin
        if (run_clr) begin
            wr_cnt <= 0;
            wr_bad <= 0;
        end else if (ena1 && wea1[0]) begin
            if (int'(addra1) != wr_cnt) wr_bad <= wr_bad + 1;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ramp_errs();
        int n = 0;
        for (int i = 0; i < 64; i++) if (mem1[i] !== 11'(i)) n++;
        return n;
    endfunction

    function automatic logic [31:0] outs_vec1();
        return 32'({s_ready1, ena1, wea1, busy1, done1, error1, addra1, dina1});
    endfunction

    // Runs one load. bp != 0 drops s_valid on every third cycle. start_at re-pulses start.
    // rst_at asserts reset part-way through the clock period that follows that edge.
    task automatic run_load(input int bp, input int start_at, input int rst_at,
                            output int d1, output int d2, output int er1, output int rdy_cnt);
        int   idx;
        logic was_rdy;
        idx = 0; d1 = 0; d2 = 0; er1 = 0; rdy_cnt = 0;
        run_clr = 1'b1;
        start   = 1'b1;
        s_valid = 1'b0;
        tick();                         // edge 0
        run_clr = 1'b0;
        start   = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            s_valid = !(bp != 0 && (e % 3) == 1);
            s_data  = 11'(idx);
            start   = (e == start_at);
            was_rdy = s_ready1;
            tick();
            if (was_rdy) rdy_cnt++;
            if (was_rdy && s_valid) idx++;
            if (done1 && d1 == 0) d1 = e;
            if (done2 && d2 == 0) d2 = e;
            if (error1 && er1 == 0) er1 = e;
            if (e == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check("async_rst_outs", outs_vec1(), 32'd0);
                check("async_rst_busy2", 32'(busy2), 32'd0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        int d1, d2, er1, rc;

        // Reset state
        #1;
        check("rst_outs1", outs_vec1(), 32'd0);
        check("rst_wsum", 32'(u_dut1.write_sum_q), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_outs1", outs_vec1(), 32'd0);

        // Ramp load with s_valid held high
        run_load(0, 0, 0, d1, d2, er1, rc);
        check("ramp_done_edge", 32'(d1), 32'd130);
        check("ramp_err_edge", 32'(er1), 32'd0);
        check("ramp_rdy_cycles", 32'(rc), 32'd64);
        check("ramp_wr_order", 32'(wr_bad), 32'd0);
        check("ramp_wr_count", 32'(wr_cnt), 32'd64);
        check("ramp_mem", 32'(ramp_errs()), 32'd0);
        check("ramp_wsum", 32'(u_dut1.write_sum_q), 32'd2016);
        check("lat2_done_edge", 32'(d2), 32'd131);
        check("lat2_rsum", 32'(u_dut2.read_sum_q), 32'd2016);
        check("ramp_idle_outs", 32'({ena1, wea1, s_ready1, busy1}), 32'd0);

        // Backpressure: 32 stalled cycles during WRITE
        for (int i = 0; i < 64; i++) mem1[i] = 11'h7ff;
        run_load(1, 0, 0, d1, d2, er1, rc);
        check("bp_done_edge", 32'(d1), 32'd162);
        check("bp_lat2_done_edge", 32'(d2), 32'd163);
        check("bp_rdy_cycles", 32'(rc), 32'd96);
        check("bp_wr_order", 32'(wr_bad), 32'd0);
        check("bp_wr_count", 32'(wr_cnt), 32'd64);
        check("bp_mem", 32'(ramp_errs()), 32'd0);

        // Corruption at address 5 on readback
        corrupt = 1'b1;
        run_load(0, 0, 0, d1, d2, er1, rc);
        corrupt = 1'b0;
        check("corr_err_edge", 32'(er1), 32'd130);
        check("corr_done_edge", 32'(d1), 32'd0);
        check("corr_flags", 32'({done1, error1}), 32'd1);
        run_load(0, 0, 0, d1, d2, er1, rc);
        check("clean_done_edge", 32'(d1), 32'd130);
        check("clean_err_edge", 32'(er1), 32'd0);

        // start pulsed during WRITE is ignored
        run_load(0, 40, 0, d1, d2, er1, rc);
        check("ign_done_edge", 32'(d1), 32'd130);
        check("ign_wr_order", 32'(wr_bad), 32'd0);
        check("ign_wr_count", 32'(wr_cnt), 32'd64);

        // Asynchronous reset in VERIFY, then a fresh load
        run_load(0, 0, 70, d1, d2, er1, rc);
        check("rst_after_outs", outs_vec1(), 32'd0);
        run_load(0, 0, 0, d1, d2, er1, rc);
        check("post_rst_done_edge", 32'(d1), 32'd130);
        check("post_rst_mem", 32'(ramp_errs()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
